// File: rtl/fetch_debug_controller.sv
// ---------------------------------------------------------------------------
// fetch_debug_controller
//
// Debug-side sequencer for the instruction-fetch stage. Assembles 32-bit
// program words from a UART byte stream (little-endian), writes them into
// instruction memory through the fetch stage's write port, then gates the
// stage's step enable for continuous run ('C') or single step ('S').
// Execution stops when the fetched instruction equals HALT_WORD.
//
// Optional feature macro: CYCLE_LIMIT_EN
//   defined   -> run watchdog; after MAX_RUN_CYCLES step cycles the run is
//                forced to HALT and o_timeout is set (sticky until reset).
//   undefined -> no watchdog counter is built; o_timeout is tied to 0.
//
// Ports
//   i_clk            clock
//   i_rst            asynchronous, active-low reset
//   i_rx_valid       one-cycle strobe, i_rx_data valid
//   i_rx_data        received byte
//   i_fetched_instr  instruction currently output by the fetch stage
//   o_inst_mem_wr_en one-cycle instruction memory write pulse
//   o_inst_mem_addr  byte write address (word index * 4)
//   o_inst_mem_data  write data
//   o_step           advance enable for PC and cycle counter (combinational)
//   o_state          current FSM state code
//   o_halted         high while in HALT (registered)
//   o_load_err       sticky: a load exceeded MEM_DEPTH
//   o_timeout        sticky watchdog flag
// ---------------------------------------------------------------------------
module fetch_debug_controller #(
    parameter int              NBITS          = 32,
    parameter int              MEM_DEPTH      = 256,
    parameter logic [NBITS-1:0] HALT_WORD     = 32'hFFFF_FFFF,
    parameter int              MAX_RUN_CYCLES = 4096
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_data,
    input  logic [NBITS-1:0] i_fetched_instr,
    output logic             o_inst_mem_wr_en,
    output logic [NBITS-1:0] o_inst_mem_addr,
    output logic [NBITS-1:0] o_inst_mem_data,
    output logic             o_step,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic             o_load_err,
    output logic             o_timeout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CNT  = 3'd1,
        LOAD_DATA = 3'd2,
        RUN       = 3'd3,
        HALT      = 3'd4
    } state_t;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_CONT  = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_PAUSE = 8'h50;

    state_t           r_state;
    logic             r_step_req;
    logic             r_halted;
    logic             r_load_err;
    logic             r_wr_en;
    logic [NBITS-1:0] r_addr;
    logic [NBITS-1:0] r_wr_data;
    logic [23:0]      r_partial;    // first three bytes of the word in flight
    logic [1:0]       r_byte_cnt;
    logic [7:0]       r_index;      // word index of the word in flight
    logic [7:0]       r_word_cnt;   // N from the LOAD_CNT byte

    logic w_halt_hit;
    logic w_timeout_hit;

    assign w_halt_hit = (i_fetched_instr == HALT_WORD);

`ifdef CYCLE_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_RUN_CYCLES + 1);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_RUN_CYCLES);

    logic [CNT_W-1:0] r_run_cnt;
    logic             r_timeout;

    // The counter is held at zero outside RUN, so it starts from zero on
    // every RUN entry; RUN is left on the limit cycle, so it never wraps.
    assign w_timeout_hit = (r_state == RUN) && (r_run_cnt == RUN_LIMIT);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_run_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_run_cnt <= (r_state == RUN) ? r_run_cnt + 1'b1 : '0;
            if (w_timeout_hit)
                r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign o_timeout     = 1'b0;
`endif

    // Halt (and the watchdog) must kill the step in the same cycle the
    // condition appears, so this path stays combinational.
    assign o_step = ((r_state == RUN) | r_step_req) & ~w_halt_hit & ~w_timeout_hit;

    // NOTE: every register in this block uses non-blocking assignment so all
    // state updates see pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_step_req <= 1'b0;
            r_halted   <= 1'b0;
            r_load_err <= 1'b0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_partial  <= '0;
            r_byte_cnt <= '0;
            r_index    <= '0;
            r_word_cnt <= '0;
        end else begin
            // Pulses default low; only the assigning branch raises them.
            r_wr_en    <= 1'b0;
            r_step_req <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_step_req && w_halt_hit) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                r_state    <= LOAD_CNT;
                                r_load_err <= 1'b0;
                                r_index    <= '0;
                                r_byte_cnt <= '0;
                            end
                            CMD_CONT: r_state    <= RUN;
                            CMD_STEP: r_step_req <= 1'b1;
                            default:  ;
                        endcase
                    end
                end

                LOAD_CNT: begin
                    if (i_rx_valid) begin
                        r_word_cnt <= i_rx_data;
                        r_state    <= (i_rx_data == 8'd0) ? IDLE : LOAD_DATA;
                    end
                end

                LOAD_DATA: begin
                    if (i_rx_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            // Out-of-range words are still consumed so the
                            // byte stream stays aligned to the word count.
                            if (32'(r_index) < MEM_DEPTH) begin
                                r_wr_en   <= 1'b1;
                                r_addr    <= NBITS'({r_index, 2'b00});
                                r_wr_data <= NBITS'({i_rx_data, r_partial});
                            end else begin
                                r_load_err <= 1'b1;
                            end
                            r_index <= r_index + 8'd1;
                            if (r_index == r_word_cnt - 8'd1)
                                r_state <= IDLE;
                        end else begin
                            r_partial[8*r_byte_cnt +: 8] <= i_rx_data;
                        end
                    end
                end

                RUN: begin
                    // Halt wins over a simultaneous pause byte.
                    if (w_halt_hit || w_timeout_hit) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (i_rx_valid && i_rx_data == CMD_PAUSE) begin
                        r_state <= IDLE;
                    end
                end

                HALT: begin
                    if (i_rx_valid && i_rx_data == CMD_LOAD) begin
                        r_state    <= LOAD_CNT;
                        r_halted   <= 1'b0;
                        r_load_err <= 1'b0;
                        r_index    <= '0;
                        r_byte_cnt <= '0;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign o_inst_mem_wr_en = r_wr_en;
    assign o_inst_mem_addr  = r_addr;
    assign o_inst_mem_data  = r_wr_data;
    assign o_state          = r_state;
    assign o_halted         = r_halted;
    assign o_load_err       = r_load_err;

endmodule
